mgc_axi_wr_arbiter: RTL and testbench
=====================================

Name: mgc_axi_wr_arbiter

Overview:
- N-to-1 arbiter that shares one AXI write-capable master port among N_REQ upstream requesters.
- Covers three channels: AW (address), W (write data) and B (write response).
- AW: round-robin granted; the grant order is recorded in an order FIFO.
- W: routed strictly in AW grant order.
- B: routed back by an index prepended to AWID.
- Sits between requester stimulus and the AXI master HDL BFM pin interface.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 32, AWADDR width.
- WDATA_WIDTH, 32, WDATA width; WSTRB is WDATA_WIDTH/8.
- ID_WIDTH, 4, requester-side ID width.
- IDX_W, $clog2(N_REQ), requester index width; master-side ID width is ID_WIDTH+IDX_W.
- WQ_DEPTH, 8, order FIFO depth (power of 2).

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  async active-low reset
- s_awvalid / s_awready  in / out  N_REQ  per-requester AW handshake
- s_awaddr  in  N_REQ*ADDR_WIDTH  flattened addresses
- s_awlen  in  N_REQ*8  burst lengths
- s_awid  in  N_REQ*ID_WIDTH  IDs
- s_wvalid / s_wready  in / out  N_REQ  W handshake
- s_wdata  in  N_REQ*WDATA_WIDTH  write data
- s_wstrb  in  N_REQ*WDATA_WIDTH/8  write strobes
- s_wlast  in  N_REQ  last beat
- s_bvalid / s_bready  out / in  N_REQ  B handshake
- s_bresp  out  2  broadcast response
- s_bid  out  ID_WIDTH  broadcast original ID
- m_awvalid / m_awready  out / in  1  master AW handshake
- m_awaddr  out  ADDR_WIDTH  muxed address
- m_awlen  out  8  muxed burst length
- m_awid  out  ID_WIDTH+IDX_W  {idx, id}
- m_wvalid / m_wready  out / in  1  master W handshake
- m_wdata / m_wstrb / m_wlast  out  WDATA_WIDTH / WDATA_WIDTH/8 / 1  muxed write beat
- m_bvalid / m_bready  in / out  1  master B handshake
- m_bresp  in  2  write response
- m_bid  in  ID_WIDTH+IDX_W  response ID

Behaviour:
- Reset (ARESETn low, async):
  - State returns to IDLE; round-robin pointer set to 0 (so requester 0 has highest priority first); order FIFO emptied.
  - All valid/ready outputs are 0; m_awaddr/m_awlen/m_awid/m_wdata/m_wstrb/m_wlast are 0.
  - Reset mid-burst abandons the burst; nothing is replayed.
- AW FSM:
  - IDLE: if any s_awvalid and the FIFO is not full, pick the first asserted requester at or after the RR pointer, register grant index g, go to ADDR.
  - ADDR: m_awvalid=1 with the muxed fields of g (registered); s_awready[g]=m_awready.
    - On handshake: push g to the FIFO, set RR pointer to g+1 mod N_REQ, return to IDLE.
  - Result is one grant per 2 cycles minimum. Latency: s_awvalid at cycle t gives m_awvalid at t+1.
- FIFO full in IDLE: no grant is made; s_awvalid is left pending. A push is blocked while full even if a pop happens in the same cycle; the grant is made the next cycle.
- W routing (combinational), with h = FIFO head:
  - m_wvalid = !empty & s_wvalid[h]; s_wready[h] = !empty & m_wready; all other s_wready are 0.
  - Pop on m_wvalid & m_wready & m_wlast.
  - W beats may arrive before their AW is granted; they simply wait (s_wready=0).
- Simultaneous FIFO push and pop (not full) are both taken; the count is unchanged.
- B routing (combinational):
  - s_bvalid[m_bid[top IDX_W bits]] = m_bvalid; s_bid = m_bid low bits; s_bresp = m_bresp.
  - m_bready = s_bready of the indexed requester.
  - An index ≥ N_REQ drops the response: m_bready=1, no s_bvalid.
- The arbiter does not count beats; WLAST alone terminates routing.

Optional Feature:
- MGC_AXI_ARB_QOS_EN
  - Defined: adds input s_awqos (N_REQ*4). IDLE grants the highest AWQOS among valid requesters; ties are broken round-robin from the pointer.
  - Undefined: pure round-robin; no s_awqos port.

Decomposition:
- Package mgc_axi_arb_pkg holds:
  - arb_state_e {IDLE, ADDR};
  - function rr_pick(valid vector, pointer) returning an index;
  - constant BRESP_OKAY=2'b00.
- Sub-module mgc_axi_arb_order_fifo: a WQ_DEPTH×IDX_W synchronous FIFO with push/pop/full/empty/head and async active-low reset.

Test Plan:
- Single requester: s_awvalid[1], awaddr 0x100, awlen 3 → m_awvalid at t+1 with m_awid={2'd1,id}; 4 W beats pass; m_bid=6'h1x → s_bvalid[1] only.
- All 4 requesters valid continuously → grant order 0,1,2,3,0; m_awvalid every other cycle.
- W before AW: requester 2 drives wvalid 5 cycles early → s_wready[2]=0 until its grant is at the FIFO head.
- Fill the FIFO with 8 AWs while m_wready=0 → the 9th AW is not granted. One WLAST pop → the 9th is granted the following cycle.
- ARESETn pulsed low mid-burst (beat 2 of 4) → all outputs 0 immediately; FIFO empty; RR pointer 0 after release.
- QOS_EN: qos {1,7,7,3}, pointer 0 → grants 1 then 2; then 3 once 1 and 2 are idle.

Source files
------------

// File: rtl/mgc_axi_arb_pkg.sv
// Shared types and helpers for the mgc_axi_wr_arbiter slice.
// Holds the AW FSM state enum, the round-robin pick function and the OKAY response code.
package mgc_axi_arb_pkg;

  typedef enum logic {IDLE, ADDR} arb_state_e;

  localparam logic [1:0] BRESP_OKAY = 2'b00;
  localparam int         MAX_REQ    = 8;

  // First asserted bit at or after ptr, wrapping modulo n (n <= MAX_REQ).
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0]         ptr,
                                         input int                 n);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = (int'(ptr) + i) % n;
      if (i < n && !found && valid[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mgc_axi_arb_order_fifo.sv
// Order FIFO recording AW grant indices so W beats are routed in grant order.
// Push is ignored while full and pop while empty; simultaneous push/pop keeps the count.
module mgc_axi_arb_order_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

  // Storage carries no reset; the head is only consumed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mgc_axi_wr_arbiter.sv
// N-to-1 AXI write arbiter: round-robin AW, W routed in grant order, B routed by the AWID index prefix.
// Define MGC_AXI_ARB_QOS_EN to add s_awqos and grant the highest QoS first (ties round-robin).
module mgc_axi_wr_arbiter
  import mgc_axi_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int WDATA_WIDTH = 32,
  parameter int ID_WIDTH    = 4,
  parameter int IDX_W       = $clog2(N_REQ),
  parameter int WQ_DEPTH    = 8
) (
  input  logic                             ACLK,
  input  logic                             ARESETn,
  input  logic [N_REQ-1:0]                 s_awvalid,
  output logic [N_REQ-1:0]                 s_awready,
  input  logic [N_REQ*ADDR_WIDTH-1:0]      s_awaddr,
  input  logic [N_REQ*8-1:0]               s_awlen,
  input  logic [N_REQ*ID_WIDTH-1:0]        s_awid,
`ifdef MGC_AXI_ARB_QOS_EN
  input  logic [N_REQ*4-1:0]               s_awqos,
`endif
  input  logic [N_REQ-1:0]                 s_wvalid,
  output logic [N_REQ-1:0]                 s_wready,
  input  logic [N_REQ*WDATA_WIDTH-1:0]     s_wdata,
  input  logic [N_REQ*(WDATA_WIDTH/8)-1:0] s_wstrb,
  input  logic [N_REQ-1:0]                 s_wlast,
  output logic [N_REQ-1:0]                 s_bvalid,
  input  logic [N_REQ-1:0]                 s_bready,
  output logic [1:0]                       s_bresp,
  output logic [ID_WIDTH-1:0]              s_bid,
  output logic                             m_awvalid,
  input  logic                             m_awready,
  output logic [ADDR_WIDTH-1:0]            m_awaddr,
  output logic [7:0]                       m_awlen,
  output logic [ID_WIDTH+IDX_W-1:0]        m_awid,
  output logic                             m_wvalid,
  input  logic                             m_wready,
  output logic [WDATA_WIDTH-1:0]           m_wdata,
  output logic [WDATA_WIDTH/8-1:0]         m_wstrb,
  output logic                             m_wlast,
  input  logic                             m_bvalid,
  output logic                             m_bready,
  input  logic [1:0]                       m_bresp,
  input  logic [ID_WIDTH+IDX_W-1:0]        m_bid
);

  localparam int STRB_W = WDATA_WIDTH / 8;

  arb_state_e                state, state_next;
  logic [IDX_W-1:0]          g, g_next;
  logic [IDX_W-1:0]          rr_ptr, rr_ptr_next;
  logic                      grant;
  logic [N_REQ-1:0]          cand;
  logic [ADDR_WIDTH-1:0]     aw_addr_q;
  logic [7:0]                aw_len_q;
  logic [ID_WIDTH+IDX_W-1:0] aw_id_q;

  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [IDX_W-1:0]          head;
  logic [IDX_W-1:0]          b_idx;

`ifdef MGC_AXI_ARB_QOS_EN
  // Only requesters sharing the highest valid QoS compete in the round-robin pick.
  logic [3:0] max_qos;
  always_comb begin
    max_qos = '0;
    cand    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (s_awvalid[i] && s_awqos[i*4 +: 4] > max_qos) max_qos = s_awqos[i*4 +: 4];
    end
    for (int i = 0; i < N_REQ; i++) begin
      cand[i] = s_awvalid[i] && (s_awqos[i*4 +: 4] == max_qos);
    end
  end
`else
  assign cand = s_awvalid;
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= IDLE;
      g         <= '0;
      rr_ptr    <= '0;
      aw_addr_q <= '0;
      aw_len_q  <= '0;
      aw_id_q   <= '0;
    end else begin
      state  <= state_next;
      g      <= g_next;
      rr_ptr <= rr_ptr_next;
      if (grant) begin
        aw_addr_q <= s_awaddr[int'(g_next)*ADDR_WIDTH +: ADDR_WIDTH];
        aw_len_q  <= s_awlen[int'(g_next)*8 +: 8];
        aw_id_q   <= {g_next, s_awid[int'(g_next)*ID_WIDTH +: ID_WIDTH]};
      end
    end
  end

  always_comb begin
    state_next  = state;
    g_next      = g;
    rr_ptr_next = rr_ptr;
    grant       = 1'b0;
    unique case (state)
      IDLE: begin
        if (|s_awvalid && !fifo_full) begin
          grant      = 1'b1;
          g_next     = IDX_W'(rr_pick(MAX_REQ'(cand), 3'(rr_ptr), N_REQ));
          state_next = ADDR;
        end
      end
      ADDR: begin
        if (m_awready) begin
          state_next  = IDLE;
          rr_ptr_next = IDX_W'((int'(g) + 1) % N_REQ);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_awready = '0;
    m_awvalid = (state == ADDR);
    if (state == ADDR) s_awready[g] = m_awready;
  end

  assign m_awaddr  = aw_addr_q;
  assign m_awlen   = aw_len_q;
  assign m_awid    = aw_id_q;
  assign fifo_push = (state == ADDR) && m_awready;
  assign fifo_pop  = m_wvalid && m_wready && m_wlast;

  mgc_axi_arb_order_fifo #(
    .DEPTH (WQ_DEPTH),
    .WIDTH (IDX_W)
  ) u_order_fifo (
    .clk       (ACLK),
    .rst_n     (ARESETn),
    .push      (fifo_push),
    .push_data (g),
    .pop       (fifo_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // W follows the FIFO head only; beats from other requesters wait with wready low.
  always_comb begin
    s_wready = '0;
    m_wvalid = 1'b0;
    m_wdata  = '0;
    m_wstrb  = '0;
    m_wlast  = 1'b0;
    if (!fifo_empty) begin
      m_wvalid       = s_wvalid[head];
      s_wready[head] = m_wready;
      m_wdata        = s_wdata[int'(head)*WDATA_WIDTH +: WDATA_WIDTH];
      m_wstrb        = s_wstrb[int'(head)*STRB_W +: STRB_W];
      m_wlast        = s_wlast[head];
    end
  end

  assign b_idx   = m_bid[ID_WIDTH+IDX_W-1 -: IDX_W];
  assign s_bid   = m_bid[ID_WIDTH-1:0];
  assign s_bresp = m_bresp;

  // An out-of-range index is accepted and dropped so the master never stalls on it.
  always_comb begin
    s_bvalid = '0;
    m_bready = 1'b0;
    if (ARESETn) begin
      if (int'(b_idx) < N_REQ) begin
        s_bvalid[b_idx] = m_bvalid;
        m_bready        = s_bready[b_idx];
      end else begin
        m_bready = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mgc_axi_wr_arbiter.sv
// Directed self-checking bench for mgc_axi_wr_arbiter (default build, 4 requesters).
// Covers single transfer, round-robin order, W-before-AW, FIFO full and mid-burst reset.
module tb_mgc_axi_wr_arbiter;

  logic         ACLK;
  logic         ARESETn;
  logic [3:0]   s_awvalid, s_awready;
  logic [127:0] s_awaddr;
  logic [31:0]  s_awlen;
  logic [15:0]  s_awid;
  logic [3:0]   s_wvalid, s_wready;
  logic [127:0] s_wdata;
  logic [15:0]  s_wstrb;
  logic [3:0]   s_wlast;
  logic [3:0]   s_bvalid, s_bready;
  logic [1:0]   s_bresp;
  logic [3:0]   s_bid;
  logic         m_awvalid, m_awready;
  logic [31:0]  m_awaddr;
  logic [7:0]   m_awlen;
  logic [5:0]   m_awid;
  logic         m_wvalid, m_wready;
  logic [31:0]  m_wdata;
  logic [3:0]   m_wstrb;
  logic         m_wlast;
  logic         m_bvalid, m_bready;
  logic [1:0]   m_bresp;
  logic [5:0]   m_bid;

  int tests_run  = 0;
  int fail_count = 0;

  mgc_axi_wr_arbiter dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_awaddr  (s_awaddr),
    .s_awlen   (s_awlen),
    .s_awid    (s_awid),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wlast   (s_wlast),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .s_bresp   (s_bresp),
    .s_bid     (s_bid),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .m_awaddr  (m_awaddr),
    .m_awlen   (m_awlen),
    .m_awid    (m_awid),
    .m_wvalid  (m_wvalid),
    .m_wready  (m_wready),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_wlast   (m_wlast),
    .m_bvalid  (m_bvalid),
    .m_bready  (m_bready),
    .m_bresp   (m_bresp),
    .m_bid     (m_bid)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clearInputs();
    s_awvalid = '0; s_awaddr = '0; s_awlen = '0; s_awid = '0;
    s_wvalid  = '0; s_wdata  = '0; s_wstrb = '0; s_wlast = '0;
    s_bready  = '0;
    m_awready = 1'b0; m_wready = 1'b0;
    m_bvalid  = 1'b0; m_bresp  = 2'b00; m_bid = '0;
  endtask

  task automatic applyReset();
    clearInputs();
    ARESETn = 1'b0;
    step();
    step();
    ARESETn = 1'b1;
    step();
  endtask

  initial begin
    clearInputs();
    ARESETn = 1'b0;
    step();
    step();
    checkOutput("rst_m_awvalid", 64'(m_awvalid), 64'd0);
    checkOutput("rst_s_awready", 64'(s_awready), 64'd0);
    checkOutput("rst_m_wvalid",  64'(m_wvalid),  64'd0);
    checkOutput("rst_m_awaddr",  64'(m_awaddr),  64'd0);
    checkOutput("rst_m_bready",  64'(m_bready),  64'd0);
    ARESETn = 1'b1;
    step();

    // Single requester 1, awlen 3, four beats, then B routing.
    s_awvalid = 4'b0010;
    s_awaddr[32 +: 32] = 32'h100;
    s_awlen[8 +: 8] = 8'd3;
    s_awid[4 +: 4] = 4'h5;
    #1;
    checkOutput("t1_awvalid_t", 64'(m_awvalid), 64'd0);
    step();
    checkOutput("t1_awvalid_t1", 64'(m_awvalid), 64'd1);
    checkOutput("t1_awaddr", 64'(m_awaddr), 64'h100);
    checkOutput("t1_awlen", 64'(m_awlen), 64'd3);
    checkOutput("t1_awid", 64'(m_awid), 64'h15);
    checkOutput("t1_awready_hold", 64'(s_awready), 64'd0);
    m_awready = 1'b1;
    #1;
    checkOutput("t1_awready", 64'(s_awready), 64'b0010);
    step();
    s_awvalid = '0;
    m_awready = 1'b0;
    #1;
    checkOutput("t1_awvalid_done", 64'(m_awvalid), 64'd0);
    s_wvalid = 4'b0010;
    m_wready = 1'b1;
    s_wstrb[4 +: 4] = 4'hF;
    for (int i = 0; i < 4; i++) begin
      s_wdata[32 +: 32] = 32'hA0 + 32'(i);
      s_wlast[1] = (i == 3);
      #1;
      checkOutput("t1_wvalid", 64'(m_wvalid), 64'd1);
      checkOutput("t1_wdata", 64'(m_wdata), 64'hA0 + 64'(i));
      checkOutput("t1_wlast", 64'(m_wlast), 64'(i == 3));
      checkOutput("t1_wready", 64'(s_wready), 64'b0010);
      step();
    end
    checkOutput("t1_wready_after", 64'(s_wready), 64'd0);
    checkOutput("t1_wvalid_after", 64'(m_wvalid), 64'd0);
    s_wvalid = '0; s_wlast = '0; m_wready = 1'b0;
    m_bvalid = 1'b1; m_bid = 6'h15; m_bresp = 2'b10; s_bready = 4'b0010;
    #1;
    checkOutput("t1_bvalid", 64'(s_bvalid), 64'b0010);
    checkOutput("t1_bid", 64'(s_bid), 64'h5);
    checkOutput("t1_bresp", 64'(s_bresp), 64'b10);
    checkOutput("t1_bready", 64'(m_bready), 64'd1);
    s_bready = 4'b1101;
    #1;
    checkOutput("t1_bready_low", 64'(m_bready), 64'd0);
    m_bid = 6'h2A;
    #1;
    checkOutput("t1_bvalid_idx2", 64'(s_bvalid), 64'b0100);
    checkOutput("t1_bid_idx2", 64'(s_bid), 64'hA);
    m_bvalid = 1'b0;

    // All four requesters valid: grants 0,1,2,3,0 every other cycle.
    applyReset();
    for (int i = 0; i < 4; i++) s_awid[i*4 +: 4] = 4'(8 + i);
    s_awvalid = 4'hF;
    m_awready = 1'b1;
    #1;
    checkOutput("t2_awvalid_t", 64'(m_awvalid), 64'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      checkOutput("t2_awvalid", 64'(m_awvalid), 64'd1);
      checkOutput("t2_awid", 64'(m_awid), 64'(((k % 4) << 4) | (8 + (k % 4))));
      checkOutput("t2_awready", 64'(s_awready), 64'(1 << (k % 4)));
      step();
      checkOutput("t2_awvalid_gap", 64'(m_awvalid), 64'd0);
    end

    // W from requester 2 arrives five cycles before its AW.
    applyReset();
    s_wvalid = 4'b0100;
    s_wlast = 4'b0100;
    s_wdata[64 +: 32] = 32'hDEAD0002;
    m_wready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("t3_wready_early", 64'(s_wready), 64'd0);
      step();
    end
    s_awvalid = 4'b0100;
    m_awready = 1'b1;
    step();
    checkOutput("t3_grant_idx", 64'(m_awid[5:4]), 64'd2);
    checkOutput("t3_wready_addr", 64'(s_wready), 64'd0);
    step();
    s_awvalid = '0;
    #1;
    checkOutput("t3_wready_head", 64'(s_wready), 64'b0100);
    checkOutput("t3_wvalid", 64'(m_wvalid), 64'd1);
    checkOutput("t3_wdata", 64'(m_wdata), 64'hDEAD0002);
    step();
    checkOutput("t3_wready_popped", 64'(s_wready), 64'd0);

    // Fill the order FIFO, then free one slot with a WLAST pop.
    applyReset();
    s_awvalid = 4'b0001;
    m_awready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      step();
    end
    step();
    checkOutput("t4_full_nogrant", 64'(m_awvalid), 64'd0);
    step();
    checkOutput("t4_full_nogrant2", 64'(m_awvalid), 64'd0);
    checkOutput("t4_wready_blocked", 64'(s_wready), 64'd0);
    s_wvalid = 4'b0001;
    s_wlast = 4'b0001;
    m_wready = 1'b1;
    #1;
    checkOutput("t4_pop_wvalid", 64'(m_wvalid), 64'd1);
    step();
    m_wready = 1'b0;
    s_wvalid = '0;
    #1;
    checkOutput("t4_pop_cycle_nogrant", 64'(m_awvalid), 64'd0);
    step();
    checkOutput("t4_ninth_grant", 64'(m_awvalid), 64'd1);

    // Reset during beat 2 of a four-beat burst from requester 2.
    applyReset();
    s_awvalid = 4'b0100;
    s_awaddr[64 +: 32] = 32'h200;
    s_awlen[16 +: 8] = 8'd3;
    s_awid[8 +: 4] = 4'h3;
    m_awready = 1'b1;
    step();
    checkOutput("t5_awaddr", 64'(m_awaddr), 64'h200);
    step();
    s_awvalid = '0;
    s_wvalid = 4'b0100;
    s_wlast = '0;
    m_wready = 1'b1;
    step();
    checkOutput("t5_beat2_wvalid", 64'(m_wvalid), 64'd1);
    ARESETn = 1'b0;
    #1;
    checkOutput("t5_rst_wvalid", 64'(m_wvalid), 64'd0);
    checkOutput("t5_rst_wready", 64'(s_wready), 64'd0);
    checkOutput("t5_rst_awvalid", 64'(m_awvalid), 64'd0);
    checkOutput("t5_rst_awaddr", 64'(m_awaddr), 64'd0);
    checkOutput("t5_rst_awlen", 64'(m_awlen), 64'd0);
    checkOutput("t5_rst_awid", 64'(m_awid), 64'd0);
    step();
    ARESETn = 1'b1;
    #1;
    checkOutput("t5_fifo_empty", 64'(s_wready), 64'd0);
    s_wvalid = '0;
    s_awvalid = 4'hF;
    step();
    checkOutput("t5_rr_awvalid", 64'(m_awvalid), 64'd1);
    checkOutput("t5_rr_ptr0", 64'(m_awid[5:4]), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
